// File: rtl/chimera_clu_gate_seq.sv
// Per-cluster clock-gate sequencer: isolates AXI traffic, drains outstanding
// transactions, then gates the cluster clock; on ungate, holds isolation while clocks settle.
module chimera_clu_gate_seq #(
  parameter int unsigned NumClusters  = 5,
  parameter int unsigned CntWidth     = 6,
  parameter int unsigned WakeCycles   = 4,
  parameter int unsigned DrainTimeout = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] gate_req_i,
  input  logic [NumClusters-1:0] aw_hs_i,
  input  logic [NumClusters-1:0] ar_hs_i,
  input  logic [NumClusters-1:0] b_hs_i,
  input  logic [NumClusters-1:0] r_last_hs_i,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] gated_o,
  output logic [NumClusters-1:0] timeout_o,
  output logic [NumClusters-1:0] cnt_err_o
);

  // state | meaning
  // RUN   | clock on, traffic flows
  // DRAIN | new AW/AR blocked, waiting for outstanding count to reach zero
  // GATED | clock off, still isolated
  // WAKE  | clock back on, isolation held for WakeCycles
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_GATED = 2'b10,
    ST_WAKE  = 2'b11
  } state_e;

  localparam int unsigned WakeW  = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;
  localparam int unsigned DrainW = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
  localparam int unsigned SumW   = CntWidth + 2;
  localparam logic [WakeW-1:0]    WakeLoad  = WakeW'(WakeCycles - 1);
  localparam logic [DrainW-1:0]   DrainLoad = (DrainTimeout > 0) ? DrainW'(DrainTimeout - 1) : '0;
  localparam logic [CntWidth-1:0] CntMax    = '1;

  for (genvar g = 0; g < NumClusters; g++) begin : g_clu
    state_e              state, state_next;
    logic [CntWidth-1:0] cnt, cnt_next;
    logic [SumW-1:0]     inc, dec, sum;
    logic                err_set, any_hs;
    logic [WakeW-1:0]    wake_tmr;
    logic [DrainW-1:0]   drain_tmr;
    logic                iso_q, clk_en_q, gated_q, timeout_q, cnt_err_q;

    assign any_hs = aw_hs_i[g] | ar_hs_i[g] | b_hs_i[g] | r_last_hs_i[g];

    // Two guard bits: bit CntWidth+1 flags a negative result, bit CntWidth an overflow.
    always_comb begin
      inc      = SumW'(aw_hs_i[g]) + SumW'(ar_hs_i[g]);
      dec      = SumW'(b_hs_i[g]) + SumW'(r_last_hs_i[g]);
      sum      = {2'b00, cnt} + inc - dec;
      cnt_next = sum[CntWidth-1:0];
      err_set  = 1'b0;
      if (sum[SumW-1]) begin
        cnt_next = '0;
        err_set  = 1'b1;
      end else if (sum[CntWidth]) begin
        cnt_next = CntMax;
        err_set  = 1'b1;
      end
      if (state == ST_GATED && any_hs) err_set = 1'b1;
    end

    always_comb begin
      state_next = state;
      case (state)
        ST_RUN:   if (gate_req_i[g]) state_next = ST_DRAIN;
        ST_DRAIN: begin
          if (!gate_req_i[g])               state_next = ST_RUN;
          else if (cnt == '0 && !any_hs)    state_next = ST_GATED;
        end
        ST_GATED: if (!gate_req_i[g]) state_next = ST_WAKE;
        ST_WAKE:  if (wake_tmr == '0) state_next = ST_RUN;
        default:  state_next = ST_RUN;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state     <= ST_RUN;
        cnt       <= '0;
        wake_tmr  <= WakeLoad;
        drain_tmr <= DrainLoad;
        iso_q     <= 1'b0;
        clk_en_q  <= 1'b1;
        gated_q   <= 1'b0;
        timeout_q <= 1'b0;
        cnt_err_q <= 1'b0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
        if (err_set) cnt_err_q <= 1'b1;

        if (state != ST_WAKE)     wake_tmr <= WakeLoad;
        else if (wake_tmr != '0)  wake_tmr <= wake_tmr - WakeW'(1);

        if (state != ST_DRAIN)    drain_tmr <= DrainLoad;
        else if (drain_tmr != '0) drain_tmr <= drain_tmr - DrainW'(1);

        // Timeout is only a flag; it never forces the FSM out of DRAIN.
        if (DrainTimeout != 0 && state == ST_DRAIN && drain_tmr == '0) timeout_q <= 1'b1;

        iso_q    <= (state_next != ST_RUN);
        clk_en_q <= (state_next != ST_GATED);
        gated_q  <= (state_next == ST_GATED);
      end
    end

    assign isolate_o[g] = iso_q;
    assign clk_en_o[g]  = clk_en_q;
    assign gated_o[g]   = gated_q;
    assign timeout_o[g] = timeout_q;
    assign cnt_err_o[g] = cnt_err_q;
  end

endmodule

// File: tb/tb_chimera_clu_gate_seq.sv
// Directed bench for chimera_clu_gate_seq: a per-cycle vector table plus
// hand-written sequences for overflow, drain timeout and async reset.
module tb_chimera_clu_gate_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] gate_req, aw, ar, b, rl;
  logic [4:0] iso, cen, gat, tmo, err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  chimera_clu_gate_seq #(
    .NumClusters (5),
    .CntWidth    (6),
    .WakeCycles  (4),
    .DrainTimeout(16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .gate_req_i (gate_req),
    .aw_hs_i    (aw),
    .ar_hs_i    (ar),
    .b_hs_i     (b),
    .r_last_hs_i(rl),
    .isolate_o  (iso),
    .clk_en_o   (cen),
    .gated_o    (gat),
    .timeout_o  (tmo),
    .cnt_err_o  (err)
  );

  typedef struct {
    logic [4:0] gr, aw, ar, b, rl;
    logic [4:0] iso, cen, gat, tmo, err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] e_iso, e_cen, e_gat, e_tmo, e_err);
    chk({tag, ".isolate"}, iso, e_iso);
    chk({tag, ".clk_en"},  cen, e_cen);
    chk({tag, ".gated"},   gat, e_gat);
    chk({tag, ".timeout"}, tmo, e_tmo);
    chk({tag, ".cnt_err"}, err, e_err);
  endtask

  task automatic add(input logic [4:0] gr_v, aw_v, ar_v, b_v, rl_v,
                     input logic [4:0] iso_v, cen_v, gat_v, tmo_v, err_v);
    vec_t v;
    v.gr = gr_v; v.aw = aw_v; v.ar = ar_v; v.b = b_v; v.rl = rl_v;
    v.iso = iso_v; v.cen = cen_v; v.gat = gat_v; v.tmo = tmo_v; v.err = err_v;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input logic [4:0] gr_v, aw_v, ar_v, b_v, rl_v);
    @(negedge clk);
    gate_req = gr_v; aw = aw_v; ar = ar_v; b = b_v; rl = rl_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    gate_req = '0; aw = '0; ar = '0; b = '0; rl = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00);
    @(negedge clk);
    rst_n = 1'b1;

    //   gr     aw     ar     b      rl      iso    cen    gat    tmo    err
    // cluster 2 gated with nothing outstanding
    add(5'h00, 5'h00, 5'h00, 5'h00, 5'h00,  5'h00, 5'h1F, 5'h00, 5'h00, 5'h00);
    add(5'h04, 5'h00, 5'h00, 5'h00, 5'h00,  5'h04, 5'h1F, 5'h00, 5'h00, 5'h00);
    add(5'h04, 5'h00, 5'h00, 5'h00, 5'h00,  5'h04, 5'h1B, 5'h04, 5'h00, 5'h00);
    // cluster 0: 3 AW, 2 AR, then request; drains via 3 B + 2 R-last
    add(5'h04, 5'h01, 5'h00, 5'h00, 5'h00,  5'h04, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h04, 5'h01, 5'h00, 5'h00, 5'h00,  5'h04, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h04, 5'h01, 5'h00, 5'h00, 5'h00,  5'h04, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h04, 5'h00, 5'h01, 5'h00, 5'h00,  5'h04, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h04, 5'h00, 5'h01, 5'h00, 5'h00,  5'h04, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h00, 5'h00,  5'h05, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h00, 5'h00,  5'h05, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h01, 5'h00,  5'h05, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h01, 5'h00,  5'h05, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h01, 5'h00,  5'h05, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h00, 5'h01,  5'h05, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h05, 5'h01, 5'h00, 5'h01, 5'h00,  5'h05, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h00, 5'h00,  5'h05, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h00, 5'h01,  5'h05, 5'h1B, 5'h04, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h00, 5'h00,  5'h05, 5'h1A, 5'h05, 5'h00, 5'h00);
    // cluster 1: abort from DRAIN with cnt=4, then drain in RUN
    add(5'h07, 5'h02, 5'h02, 5'h00, 5'h00,  5'h07, 5'h1A, 5'h05, 5'h00, 5'h00);
    add(5'h07, 5'h02, 5'h02, 5'h00, 5'h00,  5'h07, 5'h1A, 5'h05, 5'h00, 5'h00);
    add(5'h07, 5'h00, 5'h00, 5'h00, 5'h00,  5'h07, 5'h1A, 5'h05, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h00, 5'h00,  5'h05, 5'h1A, 5'h05, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h02, 5'h00,  5'h05, 5'h1A, 5'h05, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h00, 5'h02,  5'h05, 5'h1A, 5'h05, 5'h00, 5'h00);
    add(5'h05, 5'h00, 5'h00, 5'h02, 5'h02,  5'h05, 5'h1A, 5'h05, 5'h00, 5'h00);
    // cluster 2 wakes: clock back at once, isolation for 4 cycles
    add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00,  5'h05, 5'h1E, 5'h01, 5'h00, 5'h00);
    add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00,  5'h05, 5'h1E, 5'h01, 5'h00, 5'h00);
    add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00,  5'h05, 5'h1E, 5'h01, 5'h00, 5'h00);
    add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00,  5'h05, 5'h1E, 5'h01, 5'h00, 5'h00);
    add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00,  5'h01, 5'h1E, 5'h01, 5'h00, 5'h00);
    // cluster 0 wakes, request re-raised mid-WAKE: one RUN cycle, then DRAIN, then abort
    add(5'h00, 5'h00, 5'h00, 5'h00, 5'h00,  5'h01, 5'h1F, 5'h00, 5'h00, 5'h00);
    add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00,  5'h01, 5'h1F, 5'h00, 5'h00, 5'h00);
    add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00,  5'h01, 5'h1F, 5'h00, 5'h00, 5'h00);
    add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00,  5'h01, 5'h1F, 5'h00, 5'h00, 5'h00);
    add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00,  5'h00, 5'h1F, 5'h00, 5'h00, 5'h00);
    add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00,  5'h01, 5'h1F, 5'h00, 5'h00, 5'h00);
    add(5'h00, 5'h00, 5'h00, 5'h00, 5'h00,  5'h00, 5'h1F, 5'h00, 5'h00, 5'h00);
    // cluster 3: B at cnt=0 flags error, count stays 0 so gating takes 2 cycles
    add(5'h00, 5'h00, 5'h00, 5'h08, 5'h00,  5'h00, 5'h1F, 5'h00, 5'h00, 5'h08);
    add(5'h08, 5'h00, 5'h00, 5'h00, 5'h00,  5'h08, 5'h1F, 5'h00, 5'h00, 5'h08);
    add(5'h08, 5'h00, 5'h00, 5'h00, 5'h00,  5'h08, 5'h17, 5'h08, 5'h00, 5'h08);
    // cluster 2: handshake while GATED flags error
    add(5'h0C, 5'h00, 5'h00, 5'h00, 5'h00,  5'h0C, 5'h17, 5'h08, 5'h00, 5'h08);
    add(5'h0C, 5'h00, 5'h00, 5'h00, 5'h00,  5'h0C, 5'h13, 5'h0C, 5'h00, 5'h08);
    add(5'h0C, 5'h04, 5'h00, 5'h00, 5'h00,  5'h0C, 5'h13, 5'h0C, 5'h00, 5'h0C);
    add(5'h0C, 5'h00, 5'h00, 5'h04, 5'h00,  5'h0C, 5'h13, 5'h0C, 5'h00, 5'h0C);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].gr, vecs[i].aw, vecs[i].ar, vecs[i].b, vecs[i].rl);
      chk_all($sformatf("v%0d", i), vecs[i].iso, vecs[i].cen, vecs[i].gat, vecs[i].tmo, vecs[i].err);
    end

    // cluster 4: +2 per cycle; the 32nd cycle would reach 64 and must saturate at 63
    for (int i = 1; i <= 32; i++) begin
      cycle(5'h0C, 5'h10, 5'h10, 5'h00, 5'h00);
      if (i == 31) chk("ovf_before", err, 5'h0C);
      if (i == 32) chk("ovf_set", err, 5'h1C);
    end
    // 31 x (-2) leaves 1 outstanding only if the counter saturated
    for (int i = 1; i <= 31; i++) cycle(5'h0C, 5'h00, 5'h00, 5'h10, 5'h10);
    cycle(5'h1C, 5'h00, 5'h00, 5'h00, 5'h00);
    chk("drain_entry.isolate", iso, 5'h1C);
    chk("drain_entry.gated", gat, 5'h0C);
    for (int i = 1; i <= 16; i++) begin
      cycle(5'h1C, 5'h00, 5'h00, 5'h00, 5'h00);
      chk($sformatf("tmo_c%0d.timeout", i), tmo, (i == 16) ? 5'h10 : 5'h00);
      chk($sformatf("tmo_c%0d.gated", i), gat, 5'h0C);
      chk($sformatf("tmo_c%0d.isolate", i), iso, 5'h1C);
    end
    cycle(5'h1C, 5'h00, 5'h00, 5'h10, 5'h00);
    chk("last_b.gated", gat, 5'h0C);
    cycle(5'h1C, 5'h00, 5'h00, 5'h00, 5'h00);
    chk_all("gated4", 5'h1C, 5'h03, 5'h1C, 5'h10, 5'h1C);

    // async reset while clusters 2..4 are gated
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk_all("async_rst", 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00);
    @(negedge clk);
    rst_n = 1'b1;
    gate_req = '0;
    cycle(5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    chk_all("post_rst", 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
